// File: rtl/hook_motion_ctrl.sv
// Hook motion controller: on each accepted frame tick, swings, extends or retracts the hook, then registers the tip position and issues one redraw request.
// Optional HOOK_OVERRUN_CNT_EN adds overrun_cnt, a saturating count of frame ticks dropped while the renderer is busy.

module hook_motion_ctrl #(
  parameter int PIVOT_X       = 160,
  parameter int PIVOT_Y       = 40,
  parameter int LEN_MIN       = 20,
  parameter int LEN_MAX       = 200,
  parameter int EXT_STEP      = 4,
  parameter int RET_STEP      = 4,
  parameter int RET_STEP_SLOW = 1,
  parameter int DEG_MIN       = 10,
  parameter int DEG_MAX       = 170,
  parameter int DEG_STEP      = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       grab,
  input  logic       carrying,
  input  logic       draw_done,
  output logic       draw_en,
  output logic [8:0] hook_degree,
  output logic [8:0] hook_x,
  output logic [9:0] hook_y,
  output logic [8:0] hook_len,
  output logic [1:0] hook_state,
  output logic       cycle_done
`ifdef HOOK_OVERRUN_CNT_EN
  , output logic [7:0] overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_SWING   = 2'd0,
    ST_EXTEND  = 2'd1,
    ST_RETRACT = 2'd2
  } state_t;

  localparam logic [8:0] D_MIN  = 9'(DEG_MIN);
  localparam logic [8:0] D_MAX  = 9'(DEG_MAX);
  localparam logic [8:0] D_STEP = 9'(DEG_STEP);
  localparam logic [8:0] L_MIN  = 9'(LEN_MIN);
  localparam logic [8:0] L_MAX  = 9'(LEN_MAX);
  localparam logic [8:0] L_EXT  = 9'(EXT_STEP);
  localparam logic [8:0] L_RET  = 9'(RET_STEP);
  localparam logic [8:0] L_SLOW = 9'(RET_STEP_SLOW);

  // round(128*sin(2k deg)) for k = 0..45
  localparam logic [7:0] SIN_Q7 [46] = '{
    8'd0,   8'd4,   8'd9,   8'd13,  8'd18,  8'd22,  8'd27,  8'd31,  8'd35,  8'd40,
    8'd44,  8'd48,  8'd52,  8'd56,  8'd60,  8'd64,  8'd68,  8'd72,  8'd75,  8'd79,
    8'd82,  8'd86,  8'd89,  8'd92,  8'd95,  8'd98,  8'd101, 8'd104, 8'd106, 8'd109,
    8'd111, 8'd113, 8'd115, 8'd117, 8'd119, 8'd120, 8'd122, 8'd123, 8'd124, 8'd125,
    8'd126, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128
  };

  state_t             state;
  logic               dir_up;
  logic               fire_pending;
  logic               pos_pending;
  logic               wait_done;
  logic               busy;
  logic               accept;
  logic [8:0]         ang;
  logic [5:0]         idx;
  logic [7:0]         sin_v;
  logic [7:0]         cos_v;
  logic [16:0]        prod_x;
  logic [16:0]        prod_y;
  logic signed [11:0] x_raw;
  logic signed [11:0] y_raw;
  logic [8:0]         x_pos;
  logic [9:0]         y_pos;
  logic [8:0]         ret_step;
  logic [8:0]         ext_len;

  // Handshake: draw_en pulses once when a fresh position is registered; every output then
  // holds until draw_done is sampled high, which ends busy. Ticks seen while busy are dropped.
  assign busy       = pos_pending | wait_done;
  assign accept     = frame_tick & ~busy;
  assign hook_state = state;

  always_comb begin
    ang    = (hook_degree <= 9'd90) ? hook_degree : 9'd180 - hook_degree;
    idx    = 6'(ang >> 1);
    sin_v  = SIN_Q7[idx];
    cos_v  = SIN_Q7[6'd45 - idx];
    prod_x = 17'(hook_len) * 17'(cos_v);
    prod_y = 17'(hook_len) * 17'(sin_v);
    if (hook_degree <= 9'd90) x_raw = 12'(PIVOT_X) + 12'(prod_x >> 7);
    else                      x_raw = 12'(PIVOT_X) - 12'(prod_x >> 7);
    y_raw = 12'(PIVOT_Y) + 12'(prod_y >> 7);
    if (x_raw < 12'sd0)        x_pos = 9'd0;
    else if (x_raw > 12'sd319) x_pos = 9'd319;
    else                       x_pos = x_raw[8:0];
    if (y_raw < 12'sd0)        y_pos = 10'd0;
    else if (y_raw > 12'sd239) y_pos = 10'd239;
    else                       y_pos = y_raw[9:0];
    ret_step = carrying ? L_SLOW : L_RET;
    ext_len  = (hook_len + L_EXT >= L_MAX) ? L_MAX : hook_len + L_EXT;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_SWING;
      hook_degree  <= 9'd90;
      dir_up       <= 1'b1;
      hook_len     <= L_MIN;
      hook_x       <= 9'(PIVOT_X);
      hook_y       <= 10'(PIVOT_Y + LEN_MIN);
      draw_en      <= 1'b0;
      cycle_done   <= 1'b0;
      fire_pending <= 1'b0;
      pos_pending  <= 1'b0;
      wait_done    <= 1'b0;
    end else begin
      draw_en    <= 1'b0;
      cycle_done <= 1'b0;
      if (state == ST_SWING && fire) fire_pending <= 1'b1;
      if (wait_done && draw_done) wait_done <= 1'b0;
      if (pos_pending) begin
        pos_pending <= 1'b0;
        draw_en     <= 1'b1;
        wait_done   <= 1'b1;
        hook_x      <= x_pos;
        hook_y      <= y_pos;
      end
      if (accept) begin
        pos_pending <= 1'b1;
        case (state)
          ST_SWING: begin
            if (fire_pending) begin
              state        <= ST_EXTEND;
              fire_pending <= 1'b0;
              hook_len     <= ext_len;
            end else if (dir_up) begin
              if (hook_degree + D_STEP >= D_MAX) begin
                hook_degree <= D_MAX;
                dir_up      <= 1'b0;
              end else begin
                hook_degree <= hook_degree + D_STEP;
              end
            end else if (hook_degree <= D_MIN + D_STEP) begin
              hook_degree <= D_MIN;
              dir_up      <= 1'b1;
            end else begin
              hook_degree <= hook_degree - D_STEP;
            end
          end
          ST_EXTEND: begin
            if (grab) begin
              state <= ST_RETRACT;
            end else begin
              hook_len <= ext_len;
              if (ext_len == L_MAX) state <= ST_RETRACT;
            end
          end
          ST_RETRACT: begin
            if (hook_len <= L_MIN + ret_step) begin
              hook_len   <= L_MIN;
              state      <= ST_SWING;
              cycle_done <= 1'b1;
            end else begin
              hook_len <= hook_len - ret_step;
            end
          end
          default: state <= ST_SWING;
        endcase
      end
    end
  end

`ifdef HOOK_OVERRUN_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun_cnt <= 8'd0;
    end else if (frame_tick && busy && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Testbench for hook_motion_ctrl: directed scenarios plus a per-cycle comparison against a
// behavioural model that derives motion, timing and position from the rules with integer maths and $sin.

module tb_hook_motion_ctrl;

  localparam int PX = 160, PY = 40, LMIN = 20, LMAX = 200;
  localparam int EXT = 4, RET = 4, RSLOW = 1, DMIN = 10, DMAX = 170, DSTEP = 2;

  // clock / reset
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       frame_tick = 1'b0, fire = 1'b0, grab = 1'b0, carrying = 1'b0, draw_done = 1'b0;
  logic       draw_en, cycle_done;
  logic [8:0] hook_degree, hook_x, hook_len;
  logic [9:0] hook_y;
  logic [1:0] hook_state;
`ifdef HOOK_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  hook_motion_ctrl dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .fire        (fire),
    .grab        (grab),
    .carrying    (carrying),
    .draw_done   (draw_done),
    .draw_en     (draw_en),
    .hook_degree (hook_degree),
    .hook_x      (hook_x),
    .hook_y      (hook_y),
    .hook_len    (hook_len),
    .hook_state  (hook_state),
    .cycle_done  (cycle_done)
`ifdef HOOK_OVERRUN_CNT_EN
    , .overrun_cnt (overrun_cnt)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   en_cnt = 0;
  int   last_lat = 0;
  logic last_cd = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int m_deg, m_dir, m_len, m_state, m_pend, m_x, m_y;
  bit m_busy, m_sched, m_draw_en, m_cd;

  function automatic int sin_q7(input int a);
    real r;
    r = 128.0 * $sin(real'(a) * 3.14159265358979 / 180.0);
    return $rtoi(r + 0.5);
  endfunction

  task automatic model_pos();
    int a, dx, dy;
    a  = (m_deg <= 90) ? m_deg : 180 - m_deg;
    dx = (m_len * sin_q7(90 - a)) / 128;
    dy = (m_len * sin_q7(a)) / 128;
    m_x = (m_deg <= 90) ? PX + dx : PX - dx;
    if (m_x < 0) m_x = 0;
    if (m_x > 319) m_x = 319;
    m_y = PY + dy;
    if (m_y > 239) m_y = 239;
  endtask

  task automatic model_reset();
    m_deg = 90; m_dir = 1; m_len = LMIN; m_state = 0; m_pend = 0;
    m_x = PX; m_y = PY + LMIN;
    m_busy = 0; m_sched = 0; m_draw_en = 0; m_cd = 0;
  endtask

  task automatic model_step();
    bit acc;
    int pend_old;
    acc      = frame_tick && !m_busy;
    pend_old = m_pend;
    m_draw_en = 0;
    m_cd      = 0;
    if (m_busy && draw_done) m_busy = 0;
    if (m_sched) begin
      model_pos();
      m_draw_en = 1;
      m_busy    = 1;
      m_sched   = 0;
    end
    if (m_state == 0 && fire) m_pend = 1;
    if (acc) begin
      m_sched = 1;
      if (m_state == 0) begin
        if (pend_old != 0) begin
          m_state = 1;
          m_pend  = 0;
          m_len   = (m_len + EXT > LMAX) ? LMAX : m_len + EXT;
        end else begin
          m_deg = m_deg + m_dir * DSTEP;
          if (m_deg >= DMAX) begin m_deg = DMAX; m_dir = -1; end
          else if (m_deg <= DMIN) begin m_deg = DMIN; m_dir = 1; end
        end
      end else if (m_state == 1) begin
        if (grab) m_state = 2;
        else begin
          m_len = m_len + EXT;
          if (m_len >= LMAX) begin m_len = LMAX; m_state = 2; end
        end
      end else begin
        m_len = m_len - (carrying ? RSLOW : RET);
        if (m_len <= LMIN) begin m_len = LMIN; m_state = 0; m_cd = 1; end
      end
    end
  endtask

  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) model_reset();
    else model_step();
  end

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clock);
    if (draw_en) en_cnt++;
    if (chk_en) begin
      check("degree", hook_degree, m_deg);
      check("len", hook_len, m_len);
      check("state", hook_state, m_state);
      check("x", hook_x, m_x);
      check("y", hook_y, m_y);
      check("draw_en", draw_en, m_draw_en);
      check("cycle_done", cycle_done, m_cd);
    end
  end

  // driver tasks
  task automatic tick_and_render(input bit with_done);
    int lat;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0; last_cd = cycle_done;
    lat = 1;
    while (!draw_en && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    last_lat = lat;
    if (!draw_en) check("draw_en_wait", 0, 1);
    if (with_done) begin
      @(negedge clock); draw_done = 1'b1;
      @(negedge clock); draw_done = 1'b0;
    end
  endtask

  task automatic fire_pulse();
    @(negedge clock); fire = 1'b1;
    @(negedge clock); fire = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_degree"}, hook_degree, 90);
    check({tag, "_len"}, hook_len, LMIN);
    check({tag, "_x"}, hook_x, PX);
    check({tag, "_y"}, hook_y, PY + LMIN);
    check({tag, "_state"}, hook_state, 0);
    check({tag, "_draw_en"}, draw_en, 0);
    check({tag, "_cycle_done"}, cycle_done, 0);
  endtask

  initial begin
    int e0;
    repeat (2) @(negedge clock);
    check_reset_values("rst");
    chk_en = 1'b1;
    resetn = 1'b1;

    // first tick after reset
    tick_and_render(1);
    check("t1_lat", last_lat, 2);
    check("t1_degree", hook_degree, 92);
    check("t1_x", hook_x, 160);
    check("t1_y", hook_y, 60);

    // upper swing limit
    repeat (38) tick_and_render(1);
    check("up_168", hook_degree, 168);
    tick_and_render(1);
    check("up_170", hook_degree, 170);
    check("up_170_x", hook_x, 141);
    check("up_170_y", hook_y, 43);
    tick_and_render(1);
    check("up_back_168", hook_degree, 168);

    // lower swing limit
    repeat (78) tick_and_render(1);
    check("dn_12", hook_degree, 12);
    tick_and_render(1);
    check("dn_10", hook_degree, 10);
    check("dn_10_x", hook_x, 179);
    check("dn_10_y", hook_y, 43);
    tick_and_render(1);
    check("dn_back_12", hook_degree, 12);
    repeat (39) tick_and_render(1);
    check("back_90", hook_degree, 90);

    // fire, full extension and retract
    fire_pulse();
    tick_and_render(1);
    check("fire_state", hook_state, 1);
    check("fire_len", hook_len, 24);
    check("fire_x", hook_x, 160);
    check("fire_y", hook_y, 64);
    repeat (44) tick_and_render(1);
    check("ext_len_max", hook_len, 200);
    check("ext_state", hook_state, 2);
    check("ext_y_clamp", hook_y, 239);
    repeat (44) tick_and_render(1);
    check("ret_len_24", hook_len, 24);
    check("ret_state_24", hook_state, 2);
    tick_and_render(1);
    check("ret_len_min", hook_len, 20);
    check("ret_state_swing", hook_state, 0);
    check("ret_cycle_done", last_cd, 1);
    check("ret_degree", hook_degree, 90);

    // grab while carrying
    fire_pulse();
    tick_and_render(1);
    repeat (19) tick_and_render(1);
    check("grab_len_100", hook_len, 100);
    check("grab_pre_state", hook_state, 1);
    grab = 1'b1; carrying = 1'b1;
    tick_and_render(1);
    grab = 1'b0;
    check("grab_state", hook_state, 2);
    check("grab_len", hook_len, 100);
    check("grab_y", hook_y, 140);
    repeat (79) tick_and_render(1);
    check("slow_len_21", hook_len, 21);
    check("slow_state_21", hook_state, 2);
    tick_and_render(1);
    check("slow_len_min", hook_len, 20);
    check("slow_state_swing", hook_state, 0);
    check("slow_cycle_done", last_cd, 1);
    carrying = 1'b0;

    // ticks dropped while the renderer is busy
    e0 = en_cnt;
    tick_and_render(0);
    check("busy_degree", hook_degree, 92);
    repeat (3) begin
      @(negedge clock); frame_tick = 1'b1;
      @(negedge clock); frame_tick = 1'b0;
      @(negedge clock);
    end
    check("drop_degree", hook_degree, 92);
    check("drop_draw_en_count", en_cnt - e0, 1);
`ifdef HOOK_OVERRUN_CNT_EN
    check("drop_overrun", overrun_cnt, 3);
`endif
    @(negedge clock); frame_tick = 1'b1; draw_done = 1'b1;
    @(negedge clock); frame_tick = 1'b0; draw_done = 1'b0;
    repeat (3) @(negedge clock);
    check("done_tick_dropped", hook_degree, 92);
    check("done_tick_no_draw", en_cnt - e0, 1);
`ifdef HOOK_OVERRUN_CNT_EN
    check("done_tick_overrun", overrun_cnt, 4);
`endif
    tick_and_render(1);
    check("after_drop_degree", hook_degree, 94);

    // asynchronous reset in the middle of an EXTEND handshake
    fire_pulse();
    tick_and_render(1);
    check("mid_state", hook_state, 1);
    tick_and_render(0);
    check("mid_len", hook_len, 28);
    #2 resetn = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clock); resetn = 1'b1;
    @(negedge clock); draw_done = 1'b1;
    @(negedge clock); draw_done = 1'b0;
    tick_and_render(1);
    check("post_rst_lat", last_lat, 2);
    check("post_rst_degree", hook_degree, 92);
    check("post_rst_x", hook_x, 160);
    check("post_rst_y", hook_y, 60);
    check("post_rst_len", hook_len, 20);
`ifdef HOOK_OVERRUN_CNT_EN
    check("post_rst_overrun", overrun_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hook_motion_ctrl.md
# hook_motion_ctrl

Upstream motion controller for the hook renderer. Each frame tick it advances the hook's swing angle or rope length and computes the hook tip position with a fixed-point sine lookup table. It then requests one hook redraw through an enable/done handshake. The renderer consumes `hook_degree`, `hook_x` and `hook_y` as its degree/centre inputs, and `draw_en`/`draw_done` connect to its enable/done.

## Interface
Parameters:
- `PIVOT_X`, 160: rope pivot x, pixels.
- `PIVOT_Y`, 40: rope pivot y, pixels.
- `LEN_MIN`, 20: rest rope length.
- `LEN_MAX`, 200: full-extension length.
- `EXT_STEP`, 4: length increment per tick while extending.
- `RET_STEP`, 4: retract decrement per tick, empty hook.
- `RET_STEP_SLOW`, 1: retract decrement per tick while carrying.
- `DEG_MIN`, 10 and `DEG_MAX`, 170: swing limits in degrees. Both must be even.
- `DEG_STEP`, 2: swing increment per tick. Must be even.

Ports:
- `clock`, in, 1: system clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per animation frame.
- `fire`, in, 1: player launch request; level or pulse.
- `grab`, in, 1: collision with an object; sampled in EXTEND.
- `carrying`, in, 1: selects `RET_STEP_SLOW` during RETRACT.
- `draw_done`, in, 1: renderer finished.
- `draw_en`, out, 1: one-cycle redraw request.
- `hook_degree`, out, 9: angle, 0 = right, 90 = down, 180 = left.
- `hook_x`, out, 9: tip x.
- `hook_y`, out, 10: tip y.
- `hook_len`, out, 9: current rope length.
- `hook_state`, out, 2: 0 SWING, 1 EXTEND, 2 RETRACT.
- `cycle_done`, out, 1: one-cycle pulse when RETRACT returns to SWING.

## Operation
Reset values (applied asynchronously):
- `hook_degree`=90, direction = increasing, `hook_len`=`LEN_MIN`.
- `hook_x`=`PIVOT_X`, `hook_y`=`PIVOT_Y`+`LEN_MIN`.
- `hook_state`=SWING.
- `draw_en`=0, `cycle_done`=0, busy=0, fire_pending=0.

Motion FSM advances only on an accepted tick, i.e. `frame_tick`=1 and busy=0:
- SWING: degree ±= `DEG_STEP`.
  - Reaching `DEG_MAX` sets direction decreasing. Reaching `DEG_MIN` sets it increasing.
  - The limit value is output once; the following tick moves away from it.
  - If fire_pending=1, the tick moves the FSM to EXTEND instead and adds `EXT_STEP`. The degree is not advanced, and fire_pending clears.
- EXTEND: degree frozen.
  - If `grab`=1 → RETRACT and len unchanged.
  - Else len += `EXT_STEP`, saturating at `LEN_MAX`. Reaching `LEN_MAX` → RETRACT on the same tick.
- RETRACT: len -= (`carrying` ? `RET_STEP_SLOW` : `RET_STEP`).
  - Reaching ≤`LEN_MIN` clamps to `LEN_MIN`, goes to SWING, and pulses `cycle_done`.
  - Swing resumes from the frozen degree and direction.

Input sampling:
- `fire` sets fire_pending only while in SWING; it is ignored in EXTEND and RETRACT.
- `grab` is sampled only on an accepted tick in EXTEND.

Position:
- a = deg≤90 ? deg : 180−deg. LUT index = a/2, 46 entries.
- sin_q7(a) = round(128·sin a°), values 0..128. cos_q7(a) = sin_q7(90−a).
- dx = (len·cos_q7)>>7 and dy = (len·sin_q7)>>7, using 17-bit products.
- x = `PIVOT_X` + (deg≤90 ? dx : −dx), clamped to 0..319.
- y = `PIVOT_Y` + dy, clamped to 0..239.

## Timing
- Accepted tick at cycle T. Degree, len and state register at T+1. Position registers at T+2.
- `draw_en`=1 for exactly cycle T+2, and busy is set.
- All outputs stay stable from T+2 until `draw_done` is sampled high. That cycle clears busy.
- A tick during busy is dropped: no motion, no `draw_en`. A tick coinciding with the `draw_done` cycle is also dropped.
- `cycle_done` is asserted at T+1 of the tick that ends RETRACT.
- `resetn` low at any point, including mid-handshake, immediately forces the reset values. The renderer's `done` after reset is ignored.

## Configuration
- `HOOK_OVERRUN_CNT_EN` defined: adds output `overrun_cnt` (8 bits, reset 0).
  - Increments on each dropped tick and saturates at 255.
  - Tracks renderer overload.
- Undefined: the port and counter are absent. Dropped ticks are silent.

## Test plan
- Reset, then one tick with `draw_done` returned 1 cycle after `draw_en`: `draw_en` at T+2, degree 92, x=160, y=60.
- Swing from 168 increasing: ticks give 170, 168. From 12 decreasing: 10, 12.
- `fire` at degree 90, then ticks:
  - First tick: EXTEND, len 24, x=160, y=64.
  - After 45 ticks: len 200, state RETRACT.
  - 45 more ticks: len 20, SWING, `cycle_done` pulse.
- `grab` at len 100 with `carrying`=1: RETRACT at len 100, decrement 1 per tick, SWING after 80 ticks.
- Hold `draw_done`=0 and send 3 ticks: degree unchanged, single `draw_en`. With the macro, `overrun_cnt`=3.
- `resetn` low mid-EXTEND between clock edges: outputs reach reset values before the next edge. The first tick after release behaves as in test 1.
